// File: rtl/stack_frame_ctrl_if.sv
// Command handshake between a frame-control client and stack_frame_ctrl.
interface stack_frame_ctrl_if #(
    parameter int DEPTH = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd;
    logic [DEPTH:0]   cmd_n;
    logic             done;
    logic [1:0]       err;

    modport master (
        output cmd_valid, cmd, cmd_n,
        input  cmd_ready, done, err
    );

    modport slave (
        input  cmd_valid, cmd, cmd_n,
        output cmd_ready, done, err
    );
endinterface

// File: rtl/stack_frame_ctrl.sv
// CALL/RET frame controller driving a SuperStack's limits and index-reset ops.
// Define STACK_FRAME_STATS_EN to add the max_depth high-water-mark output.
module stack_frame_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int FRAMES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    stack_frame_ctrl_if.slave             cmd_if,
    input  logic [DEPTH:0]                stk_index,
    input  logic [WIDTH-1:0]              stk_tos,
    output logic [2:0]                    stk_op,
    output logic [WIDTH-1:0]              stk_data,
    output logic [DEPTH:0]                stk_offset,
    output logic [DEPTH:0]                stk_underflow_limit,
    output logic [DEPTH:0]                stk_upper_limit,
`ifdef STACK_FRAME_STATS_EN
    output logic [$clog2(FRAMES+1)-1:0]   max_depth,
`endif
    output logic [$clog2(FRAMES+1)-1:0]   frame_depth
);
    localparam int IW = DEPTH + 1;
    localparam int FW = $clog2(FRAMES + 1);

    localparam logic [2:0] OP_NONE              = 3'd0;
    localparam logic [2:0] OP_INDEX_RESET       = 3'd5;
    localparam logic [2:0] OP_INDEX_RESET_PUSH  = 3'd6;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
    localparam logic [1:0] ERR_BAD_ARGS  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALL_APPLY,
        S_RET_CAPTURE,
        S_RET_ISSUE,
        S_DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   limit;
    logic [IW-1:0]   n_q;
    logic [IW-1:0]   avail;
    logic [1:0]      chk_err;
    // frame_depth doubles as the LIFO pointer; storage is padded to a power of two.
    logic [IW-1:0]   lifo [2**FW];

    assign stk_underflow_limit = limit;
    assign stk_upper_limit     = limit;
    assign avail               = stk_index - limit;

    always_comb begin
        chk_err = ERR_NONE;
        if (!cmd_if.cmd) begin
            if (frame_depth == FW'(FRAMES))
                chk_err = ERR_OVERFLOW;
            else if (cmd_if.cmd_n > avail)
                chk_err = ERR_BAD_ARGS;
        end else begin
            if (frame_depth == '0)
                chk_err = ERR_UNDERFLOW;
            else if (cmd_if.cmd_n > IW'(1) || cmd_if.cmd_n > avail)
                chk_err = ERR_BAD_ARGS;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_CALL_APPLY)
            lifo[frame_depth] <= limit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            limit            <= '0;
            n_q              <= '0;
            frame_depth      <= '0;
            stk_op           <= OP_NONE;
            stk_data         <= '0;
            stk_offset       <= '0;
            cmd_if.done      <= 1'b0;
            cmd_if.err       <= ERR_NONE;
            cmd_if.cmd_ready <= 1'b1;
`ifdef STACK_FRAME_STATS_EN
            max_depth        <= '0;
`endif
        end else begin
            cmd_if.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_if.cmd_valid) begin
                        n_q              <= cmd_if.cmd_n;
                        cmd_if.err       <= chk_err;
                        cmd_if.cmd_ready <= 1'b0;
                        if (chk_err != ERR_NONE) begin
                            state       <= S_DONE;
                            cmd_if.done <= 1'b1;
                        end else if (cmd_if.cmd) begin
                            state <= S_RET_CAPTURE;
                        end else begin
                            state <= S_CALL_APPLY;
                        end
                    end
                end
                S_CALL_APPLY: begin
                    limit       <= stk_index - n_q;
                    frame_depth <= frame_depth + FW'(1);
`ifdef STACK_FRAME_STATS_EN
                    if (frame_depth >= max_depth)
                        max_depth <= frame_depth + FW'(1);
`endif
                    state       <= S_DONE;
                    cmd_if.done <= 1'b1;
                end
                // Outputs for RET_ISSUE are registered here, so stk_data is the TOS latch.
                S_RET_CAPTURE: begin
                    stk_op      <= (n_q == IW'(1)) ? OP_INDEX_RESET_PUSH : OP_INDEX_RESET;
                    stk_data    <= (n_q == IW'(1)) ? stk_tos : '0;
                    stk_offset  <= limit;
                    limit       <= lifo[frame_depth - FW'(1)];
                    frame_depth <= frame_depth - FW'(1);
                    state       <= S_RET_ISSUE;
                end
                S_RET_ISSUE: begin
                    stk_op      <= OP_NONE;
                    stk_data    <= '0;
                    stk_offset  <= '0;
                    state       <= S_DONE;
                    cmd_if.done <= 1'b1;
                end
                S_DONE: begin
                    state            <= S_IDLE;
                    cmd_if.cmd_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Randomized bench for stack_frame_ctrl; the bench itself plays the SuperStack.
module tb_stack_frame_ctrl;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 2;
    localparam int FRAMES = 2;
    localparam int IW     = DEPTH + 1;
    localparam int FW     = $clog2(FRAMES + 1);

    localparam int OP_NONE       = 0;
    localparam int OP_IRST       = 5;
    localparam int OP_IRST_PUSH  = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [IW-1:0]     stk_index;
    logic [WIDTH-1:0]  stk_tos;
    logic [2:0]        stk_op;
    logic [WIDTH-1:0]  stk_data;
    logic [IW-1:0]     stk_offset;
    logic [IW-1:0]     stk_underflow_limit;
    logic [IW-1:0]     stk_upper_limit;
    logic [FW-1:0]     frame_depth;
`ifdef STACK_FRAME_STATS_EN
    logic [FW-1:0]     max_depth;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference state: environment stack, current frame base, saved bases.
    int stk[$];
    int lim;
    int frames[$];
    int maxd;

    stack_frame_ctrl_if #(.DEPTH(DEPTH)) cmd_if();

    stack_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_if              (cmd_if),
        .stk_index           (stk_index),
        .stk_tos             (stk_tos),
        .stk_op              (stk_op),
        .stk_data            (stk_data),
        .stk_offset          (stk_offset),
        .stk_underflow_limit (stk_underflow_limit),
        .stk_upper_limit     (stk_upper_limit),
`ifdef STACK_FRAME_STATS_EN
        .max_depth           (max_depth),
`endif
        .frame_depth         (frame_depth)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sync_stack();
        stk_index = IW'(stk.size());
        stk_tos   = (stk.size() > 0) ? WIDTH'(stk[stk.size()-1]) : '0;
    endtask

    task automatic check_frame_state(input string tag);
        check_eq({tag, "_depth"}, frame_depth, frames.size());
        check_eq({tag, "_ulim"}, stk_underflow_limit, lim);
        check_eq({tag, "_uplim"}, stk_upper_limit, lim);
`ifdef STACK_FRAME_STATS_EN
        check_eq({tag, "_maxd"}, max_depth, maxd);
`endif
    endtask

    task automatic model_reset();
        lim = 0;
        frames.delete();
        maxd = 0;
    endtask

    task automatic do_cmd(input bit c, input int n);
        int exp_err;
        int exp_lat;
        int k;
        bit seen;
        int avail;
        int top;
        avail = stk.size() - lim;
        exp_err = 0;
        if (!c) begin
            if (frames.size() == FRAMES) exp_err = 1;
            else if (n > avail)          exp_err = 3;
        end else begin
            if (frames.size() == 0)          exp_err = 2;
            else if (n > 1 || n > avail)     exp_err = 3;
        end
        exp_lat = (exp_err != 0) ? 1 : (c ? 3 : 2);

        @(negedge clk);
        check_eq("cmd_ready", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = c;
        cmd_if.cmd_n     = IW'(n);
        @(posedge clk);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 8) begin
            @(negedge clk);
            k++;
            if (cmd_if.done) begin
                seen = 1'b1;
                cmd_if.cmd_valid = 1'b0;
            end else begin
                // Busy-time noise on the command bus must be ignored.
                cmd_if.cmd_valid = 1'($urandom_range(0, 1));
                cmd_if.cmd       = 1'($urandom_range(0, 1));
                cmd_if.cmd_n     = IW'($urandom_range(0, 7));
            end
            if (exp_err == 0 && c && k == 2) begin
                top = stk[stk.size()-1];
                check_eq("ret_op", stk_op, (n == 1) ? OP_IRST_PUSH : OP_IRST);
                check_eq("ret_offset", stk_offset, lim);
                if (n == 1) check_eq("ret_data", stk_data, top);
                check_eq("ret_ulim", stk_underflow_limit, frames[frames.size()-1]);
                check_eq("ret_depth", frame_depth, frames.size() - 1);
                while (stk.size() > lim) void'(stk.pop_back());
                if (n == 1) stk.push_back(top);
                lim = frames.pop_back();
                sync_stack();
            end else begin
                check_eq("op_none", stk_op, OP_NONE);
            end
        end
        if (!seen) cmd_if.cmd_valid = 1'b0;
        check_eq("done_seen", seen, 1);
        check_eq("latency", k, exp_lat);
        if (exp_err == 0 && !c) begin
            frames.push_back(lim);
            lim = stk.size() - n;
            if (frames.size() > maxd) maxd = frames.size();
        end
        check_eq("err", cmd_if.err, exp_err);
        check_frame_state("post");
        @(negedge clk);
        check_eq("done_pulse", cmd_if.done, 0);
        check_eq("err_hold", cmd_if.err, exp_err);
    endtask

    task automatic push_item(input int v);
        stk.push_back(v & 8'hFF);
        sync_stack();
    endtask

    initial begin
        int r;
        int avail;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd       = 1'b0;
        cmd_if.cmd_n     = '0;
        model_reset();
        sync_stack();

        repeat (2) @(negedge clk);
        check_eq("rst_op", stk_op, OP_NONE);
        check_eq("rst_data", stk_data, 0);
        check_eq("rst_offset", stk_offset, 0);
        check_eq("rst_done", cmd_if.done, 0);
        check_eq("rst_err", cmd_if.err, 0);
        check_frame_state("rst");
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", cmd_if.cmd_ready, 1);

        // Directed walk through call/return, overflow, underflow and bad-args cases.
        push_item(8'h11); push_item(8'h22); push_item(8'h33);
        do_cmd(1'b0, 2);
        push_item(8'h2A);
        do_cmd(1'b1, 1);
        do_cmd(1'b1, 1);
        do_cmd(1'b0, 0);
        do_cmd(1'b0, 0);
        do_cmd(1'b0, 0);
        do_cmd(1'b1, 0);
        do_cmd(1'b1, 0);
        do_cmd(1'b0, 3);
        do_cmd(1'b0, 0);
        do_cmd(1'b1, 2);
        do_cmd(1'b1, 0);

        repeat (200) begin
            r = $urandom_range(0, 9);
            avail = stk.size() - lim;
            if (r <= 2) begin
                if (stk.size() < 6) push_item($urandom_range(0, 255));
            end else if (r == 3) begin
                if (avail > 0) begin
                    void'(stk.pop_back());
                    sync_stack();
                end
            end else if (r <= 6) begin
                do_cmd(1'b0, $urandom_range(0, (avail + 1 > 7) ? 7 : avail + 1));
            end else begin
                do_cmd(1'b1, $urandom_range(0, 2));
            end
        end

        // Abort a return in its issue cycle with an asynchronous reset.
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        do_cmd(1'b0, 0);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = 1'b1;
        cmd_if.cmd_n     = '0;
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_pre_op", stk_op, OP_IRST);
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("abort_op", stk_op, OP_NONE);
        check_eq("abort_offset", stk_offset, 0);
        check_eq("abort_done", cmd_if.done, 0);
        check_frame_state("abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_ready", cmd_if.cmd_ready, 1);
        check_frame_state("abort_rel");
        do_cmd(1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stack_frame_ctrl.md
STACK_FRAME_CTRL -- requirements
Module: stack_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, stack data width.
REQ-002 SHALL have parameter DEPTH, default 2, giving an index/limit width of DEPTH+1 bits, matching SuperStack.
REQ-003 SHALL have parameter FRAMES, default 4, the maximum number of nested saved frames.
REQ-004 SHALL have a single clock; reset is asynchronous and active-low.
REQ-005 Port clk: input, 1 bit, clock, rising edge.
REQ-006 Port reset: input, 1 bit, asynchronous active-low reset.
REQ-007 Port cmd_valid: input, 1 bit, command request.
REQ-008 Port cmd_ready: output, 1 bit, high only in IDLE.
REQ-009 Port cmd: input, 1 bit, 0 = CALL, 1 = RET.
REQ-010 Port cmd_n: input, DEPTH+1 bits; number of arguments for CALL, number of results for RET (0 or 1 only).
REQ-011 Port stk_index: input, DEPTH+1 bits, the SuperStack index.
REQ-012 Port stk_tos: input, WIDTH bits, the SuperStack out (top of stack).
REQ-013 Port stk_op: output, 3 bits, SuperStack op using the SuperStack.svh encodings.
REQ-014 Port stk_data: output, WIDTH bits, SuperStack data.
REQ-015 Port stk_offset: output, DEPTH+1 bits, SuperStack offset, an absolute index.
REQ-016 Port stk_underflow_limit: output, DEPTH+1 bits, current frame base.
REQ-017 Port stk_upper_limit: output, DEPTH+1 bits, always equal to stk_underflow_limit.
REQ-018 Port frame_depth: output, $clog2(FRAMES+1) bits, number of saved frames.
REQ-019 Port done: output, 1 bit, one-cycle completion pulse.
REQ-020 Port err: output, 2 bits: 0 none, 1 FRAME_OVERFLOW, 2 FRAME_UNDERFLOW, 3 BAD_ARGS.

Function
REQ-021 SHALL implement the FSM IDLE -> {CALL_APPLY | RET_CAPTURE -> RET_ISSUE} -> DONE -> IDLE.
REQ-022 A command SHALL be accepted on a clk edge where cmd_valid && cmd_ready; cmd and cmd_n SHALL be latched at that edge; cmd_valid outside IDLE SHALL be ignored.
REQ-023 stk_op SHALL be NONE in every state except RET_ISSUE.
REQ-024 CALL check order, first failure wins: frame_depth == FRAMES -> FRAME_OVERFLOW; cmd_n > stk_index - limit -> BAD_ARGS.
REQ-025 A valid CALL SHALL, in CALL_APPLY: push the current limit into the internal frame LIFO; set limit = stk_index - cmd_n; increment frame_depth.
REQ-026 RET check order, first failure wins: frame_depth == 0 -> FRAME_UNDERFLOW; cmd_n > 1 or cmd_n > stk_index - limit -> BAD_ARGS.
REQ-027 RET_CAPTURE SHALL latch stk_tos.
REQ-028 RET_ISSUE SHALL drive, for one cycle: stk_offset = callee limit, the pre-pop value; stk_op = INDEX_RESET_AND_PUSH with stk_data = latched TOS if cmd_n == 1, else INDEX_RESET; stk_underflow_limit = the popped saved limit, from that same cycle; frame_depth decremented.
REQ-029 On any error, the FSM SHALL go from IDLE straight to DONE, with no change to limit, LIFO or frame_depth.
REQ-030 done SHALL pulse in DONE.
REQ-031 err SHALL be valid with done and hold until the next accepted command, which clears it.
REQ-032 Latency from accept edge to done high: CALL 2 cycles, RET 3 cycles, error 1 cycle.
REQ-033 All arithmetic SHALL be unsigned at DEPTH+1 bits; the checks in REQ-024 and REQ-026 guarantee no wrap.

Reset
REQ-034 While reset is low, the block SHALL be asynchronously forced to: state IDLE, limit 0, frame_depth 0, LIFO pointer 0, stk_op NONE, stk_data 0, stk_offset 0, done 0, err 0, cmd_ready 1 after release.
REQ-035 Reset asserted mid-sequence (e.g. in RET_ISSUE) SHALL abort it; no partial LIFO pop is retained.

Configuration
REQ-036 Macro STACK_FRAME_STATS_EN, when defined, SHALL add output max_depth ($clog2(FRAMES+1) bits): the frame_depth high-water mark, reset to 0 and saturating at FRAMES.
REQ-037 When STACK_FRAME_STATS_EN is undefined, the max_depth port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8, DEPTH=2, FRAMES=2, SuperStack instantiated with the same parameters)
REQ-038 Reset, then push 3 items (index 3), then CALL n=2 -> done 2 cycles after accept; stk_underflow_limit=1; frame_depth=1; err=0.
REQ-039 Continuing REQ-038: push 0x2A (index 4), then RET n=1 -> in RET_ISSUE, stk_op=INDEX_RESET_AND_PUSH, stk_offset=1, stk_data=0x2A; afterwards index=2, out=0x2A, limit=0, frame_depth=0.
REQ-040 RET at frame_depth 0 -> err=2 with done 1 cycle after accept; limit and index unchanged.
REQ-041 Two CALL n=0 commands then a third CALL -> third gives err=1, frame_depth stays 2; with STACK_FRAME_STATS_EN, max_depth=2.
REQ-042 CALL n=3 with index=2, limit=0 -> err=3; RET n=2 -> err=3; a following valid command -> err cleared to 0.
REQ-043 Assert reset low during RET_ISSUE -> stk_op=NONE immediately; after release, frame_depth=0, limit=0, cmd_ready=1.
